// File: rtl/id_fwd_stall_unit_pkg.sv
// Shared types and defaults for the ID-stage forwarding / stall unit.
package id_fwd_stall_unit_pkg;

  localparam int NSRC_DEF = 3;
  localparam int DW_DEF   = 32;
  localparam int AW_DEF   = 5;

  typedef logic [5:0] StallBus;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  localparam int STALL_ID = 1;
  localparam int STALL_EX = 2;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } inst_state_e;

endpackage

// File: rtl/fwd_sel.sv
// Priority forward mux: lowest-index source wins; address 0 reads as zero.
// Also flags whether any matching source is a load still in flight.
module fwd_sel
  import id_fwd_stall_unit_pkg::*;
#(
  parameter int NSRC = NSRC_DEF,
  parameter int DW   = DW_DEF,
  parameter int AW   = AW_DEF
) (
  input  logic [AW-1:0]      addr_i,
  input  logic [DW-1:0]      rf_rdata_i,
  input  logic [NSRC-1:0]    src_we_i,
  input  logic [NSRC-1:0]    src_is_load_i,
  input  logic [NSRC*AW-1:0] src_waddr_i,
  input  logic [NSRC*DW-1:0] src_wdata_i,
  output logic [DW-1:0]      val_o,
  output logic               load_hit_o
);

  always_comb begin
    val_o      = rf_rdata_i;
    load_hit_o = 1'b0;
    if (addr_i == '0) begin
      val_o = '0;
    end else begin
      // Walk oldest to youngest so the youngest match overwrites the value.
      for (int i = NSRC - 1; i >= 0; i--) begin
        if (src_we_i[i] && (src_waddr_i[i*AW +: AW] == addr_i)) begin
          val_o = src_wdata_i[i*DW +: DW];
          if (src_is_load_i[i]) begin
            load_hit_o = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/id_fwd_stall_unit.sv
// ID pipeline register with instruction-hold FSM, operand forwarding and load-use interlock.
// Forwarding and stallreq are combinational; stall_cnt counts interlock cycles and saturates.
module id_fwd_stall_unit
  import id_fwd_stall_unit_pkg::*;
#(
  parameter int          NSRC     = NSRC_DEF,
  parameter int          DW       = DW_DEF,
  parameter int          AW       = AW_DEF,
  parameter logic [31:0] CNT_INIT = 32'h0
) (
  input  logic               clk,
  input  logic               rst,
  input  StallBus            stall,
  input  logic               if_valid,
  input  logic [DW-1:0]      if_pc,
  input  logic [31:0]        inst_rdata,
  input  logic [DW-1:0]      rf_rdata1,
  input  logic [DW-1:0]      rf_rdata2,
  input  logic [NSRC-1:0]    src_we,
  input  logic [NSRC-1:0]    src_is_load,
  input  logic [NSRC*AW-1:0] src_waddr,
  input  logic [NSRC*DW-1:0] src_wdata,
  output logic               id_valid,
  output logic [DW-1:0]      id_pc,
  output logic [31:0]        id_inst,
  output logic [DW-1:0]      rs_val,
  output logic [DW-1:0]      rt_val,
  output logic               stallreq,
  output logic [31:0]        stall_cnt
);

  logic          id_valid_q, id_valid_d;
  logic [DW-1:0] id_pc_q, id_pc_d;
  logic [31:0]   hold_q, hold_d;
  inst_state_e   state_q, state_d;
  logic [31:0]   cnt_q, cnt_d;
  logic          id_stop, ex_stop, bubble;
  logic [AW-1:0] rs, rt;
  logic          rs_load_hit, rt_load_hit;
  logic          unused_stall;

  assign id_stop      = (stall[STALL_ID] == Stop);
  assign ex_stop      = (stall[STALL_EX] == Stop);
  assign bubble       = id_stop && !ex_stop;
  assign unused_stall = ^{stall[5:3], stall[0]};

  always_comb begin
    id_valid_d = id_valid_q;
    id_pc_d    = id_pc_q;
    if (bubble) begin
      id_valid_d = 1'b0;
      id_pc_d    = '0;
    end else if (!id_stop) begin
      id_valid_d = if_valid;
      id_pc_d    = if_pc;
    end
  end

  // The SRAM word is only valid on the first resident cycle, so it is latched when ID stalls.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    if (bubble) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (id_stop && id_valid_q) begin
            state_d = ST_HOLD;
            hold_d  = inst_rdata;
          end
        end
        ST_HOLD: begin
          if (!id_stop) begin
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  assign cnt_d = (stallreq && (cnt_q != 32'hFFFF_FFFF)) ? cnt_q + 32'd1 : cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid_q <= 1'b0;
      id_pc_q    <= '0;
      hold_q     <= '0;
      state_q    <= ST_RUN;
      cnt_q      <= CNT_INIT;
    end else begin
      id_valid_q <= id_valid_d;
      id_pc_q    <= id_pc_d;
      hold_q     <= hold_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
    end
  end

  assign id_valid  = id_valid_q;
  assign id_pc     = id_pc_q;
  assign id_inst   = !id_valid_q ? 32'h0 : ((state_q == ST_HOLD) ? hold_q : inst_rdata);
  assign stall_cnt = cnt_q;

  assign rs = AW'(id_inst[25:21]);
  assign rt = AW'(id_inst[20:16]);

  fwd_sel #(.NSRC(NSRC), .DW(DW), .AW(AW)) u_fwd_rs (
    .addr_i        (rs),
    .rf_rdata_i    (rf_rdata1),
    .src_we_i      (src_we),
    .src_is_load_i (src_is_load),
    .src_waddr_i   (src_waddr),
    .src_wdata_i   (src_wdata),
    .val_o         (rs_val),
    .load_hit_o    (rs_load_hit)
  );

  fwd_sel #(.NSRC(NSRC), .DW(DW), .AW(AW)) u_fwd_rt (
    .addr_i        (rt),
    .rf_rdata_i    (rf_rdata2),
    .src_we_i      (src_we),
    .src_is_load_i (src_is_load),
    .src_waddr_i   (src_waddr),
    .src_wdata_i   (src_wdata),
    .val_o         (rt_val),
    .load_hit_o    (rt_load_hit)
  );

  assign stallreq = id_valid_q && (rs_load_hit || rt_load_hit);

endmodule

// File: tb/tb_id_fwd_stall_unit.sv
// Scoreboard bench: the driver pushes model predictions, a negedge monitor pops and compares.
// A second instance starts its counter near the top to exercise saturation on the same stimulus.
module tb_id_fwd_stall_unit;

  localparam int          NSRC     = 3;
  localparam int          DW       = 32;
  localparam int          AW       = 5;
  localparam logic [31:0] SAT_INIT = 32'hFFFF_FFF0;

  logic               clk = 1'b0;
  logic               rst;
  logic [5:0]         stall;
  logic               if_valid;
  logic [DW-1:0]      if_pc;
  logic [31:0]        inst_rdata;
  logic [DW-1:0]      rf_rdata1, rf_rdata2;
  logic [NSRC-1:0]    src_we, src_is_load;
  logic [NSRC*AW-1:0] src_waddr;
  logic [NSRC*DW-1:0] src_wdata;

  logic               id_valid, stallreq;
  logic [DW-1:0]      id_pc, rs_val, rt_val;
  logic [31:0]        id_inst, stall_cnt;

  logic               unused_s_valid, unused_s_sreq;
  logic [DW-1:0]      unused_s_pc, unused_s_rs, unused_s_rt;
  logic [31:0]        unused_s_inst, s_cnt;

  always #5 clk = ~clk;

  id_fwd_stall_unit #(.NSRC(NSRC), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .if_valid(if_valid), .if_pc(if_pc),
    .inst_rdata(inst_rdata), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .src_we(src_we), .src_is_load(src_is_load), .src_waddr(src_waddr), .src_wdata(src_wdata),
    .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst), .rs_val(rs_val), .rt_val(rt_val),
    .stallreq(stallreq), .stall_cnt(stall_cnt)
  );

  id_fwd_stall_unit #(.NSRC(NSRC), .DW(DW), .AW(AW), .CNT_INIT(SAT_INIT)) dut_sat (
    .clk(clk), .rst(rst), .stall(stall), .if_valid(if_valid), .if_pc(if_pc),
    .inst_rdata(inst_rdata), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .src_we(src_we), .src_is_load(src_is_load), .src_waddr(src_waddr), .src_wdata(src_wdata),
    .id_valid(unused_s_valid), .id_pc(unused_s_pc), .id_inst(unused_s_inst),
    .rs_val(unused_s_rs), .rt_val(unused_s_rt), .stallreq(unused_s_sreq), .stall_cnt(s_cnt)
  );

  typedef struct {
    logic        valid;
    logic [31:0] pc, inst, rs, rt;
    logic        sreq;
    logic [31:0] cnt, cnt_s;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Reference model state: what the ID slot holds, not how the RTL encodes it.
  logic        m_valid, m_resident;
  logic [31:0] m_pc, m_saved, m_cnt, m_cnt_s;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
  endtask

  function automatic logic [31:0] fwd(logic [4:0] a, logic [31:0] rf);
    if (a == 5'd0) return 32'h0;
    for (int i = 0; i < NSRC; i++)
      if (src_we[i] && src_waddr[i*AW +: AW] == a) return src_wdata[i*DW +: DW];
    return rf;
  endfunction

  function automatic logic load_match(logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    for (int i = 0; i < NSRC; i++)
      if (src_we[i] && src_is_load[i] && src_waddr[i*AW +: AW] == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] sat_inc(logic [31:0] x);
    logic [32:0] s;
    s = {1'b0, x} + 33'd1;
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  function automatic logic [31:0] mk(logic [4:0] rs, logic [4:0] rt);
    return {6'h23, rs, rt, 16'h0ABC};
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_pc = '0; m_resident = 1'b0; m_saved = '0;
    m_cnt = '0; m_cnt_s = SAT_INIT;
  endtask

  task automatic set_src(int i, logic we, logic ld, logic [4:0] a, logic [31:0] d);
    src_we[i] = we;
    src_is_load[i] = ld;
    src_waddr[i*AW +: AW] = a;
    src_wdata[i*DW +: DW] = d;
  endtask

  task automatic clear_srcs();
    for (int i = 0; i < NSRC; i++) set_src(i, 1'b0, 1'b0, 5'd0, 32'h0);
  endtask

  // One clock: predict this cycle's outputs, then advance the model across the edge.
  task automatic cycle();
    exp_t        e;
    logic [31:0] w;
    logic [4:0]  a_rs, a_rt;
    logic        sr;
    w    = !m_valid ? 32'h0 : (m_resident ? m_saved : inst_rdata);
    a_rs = w[25:21];
    a_rt = w[20:16];
    sr   = m_valid && (load_match(a_rs) || load_match(a_rt));
    e.valid = m_valid; e.pc = m_pc; e.inst = w;
    e.rs = fwd(a_rs, rf_rdata1); e.rt = fwd(a_rt, rf_rdata2);
    e.sreq = sr; e.cnt = m_cnt; e.cnt_s = m_cnt_s;
    exp_q.push_back(e);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (sr) begin
        m_cnt   = sat_inc(m_cnt);
        m_cnt_s = sat_inc(m_cnt_s);
      end
      if (stall[1] && !stall[2]) begin
        m_valid = 1'b0; m_pc = '0; m_resident = 1'b0;
      end else if (!stall[1]) begin
        m_valid = if_valid; m_pc = if_pc; m_resident = 1'b0;
      end else begin
        if (m_valid && !m_resident) m_saved = inst_rdata;
        m_resident = m_valid;
      end
    end
    #1;
  endtask

  task automatic load_id(logic [31:0] pc);
    stall = 6'b000000; if_valid = 1'b1; if_pc = pc;
    cycle();
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("id_valid",  32'(id_valid), 32'(e.valid));
      chk("id_pc",     id_pc,         e.pc);
      chk("id_inst",   id_inst,       e.inst);
      chk("rs_val",    rs_val,        e.rs);
      chk("rt_val",    rt_val,        e.rt);
      chk("stallreq",  32'(stallreq), 32'(e.sreq));
      chk("stall_cnt", stall_cnt,     e.cnt);
      chk("sat_cnt",   s_cnt,         e.cnt_s);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; stall = '0; if_valid = 1'b0; if_pc = '0; inst_rdata = '0;
    rf_rdata1 = 32'hAAAA_0001; rf_rdata2 = 32'hBBBB_0002;
    clear_srcs();
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    if_valid = 1'b1; if_pc = 32'h0000_0040;
    cycle(); cycle();
    rst = 1'b0;

    // Youngest source wins over MEM for the same register.
    load_id(32'h0000_0100);
    inst_rdata = mk(5'd8, 5'd3);
    set_src(0, 1'b1, 1'b0, 5'd8, 32'h11);
    set_src(1, 1'b1, 1'b0, 5'd8, 32'h22);
    if_pc = 32'h0000_0104;
    cycle();

    // Load-use: hold ID for one cycle, then take the value from MEM.
    clear_srcs();
    inst_rdata = mk(5'd2, 5'd9);
    set_src(0, 1'b1, 1'b1, 5'd9, 32'h0);
    stall = 6'b000111;
    cycle();
    clear_srcs();
    set_src(1, 1'b1, 1'b0, 5'd9, 32'h99);
    inst_rdata = 32'h1234_5678;
    stall = 6'b000000; if_pc = 32'h0000_0108;
    cycle();
    clear_srcs();

    // Long hold while the SRAM output moves on.
    inst_rdata = mk(5'd4, 5'd5);
    stall = 6'b000110;
    cycle();
    inst_rdata = 32'hDEAD_BEEF;
    repeat (3) cycle();
    stall = 6'b000000; if_pc = 32'h0000_0200;
    cycle();
    inst_rdata = mk(5'd1, 5'd1);
    cycle();

    // r0 is never forwarded and never interlocks.
    inst_rdata = mk(5'd0, 5'd3);
    set_src(0, 1'b1, 1'b1, 5'd0, 32'h55);
    cycle();
    clear_srcs();

    // Reset in the middle of a hold.
    load_id(32'h0000_0300);
    inst_rdata = mk(5'd6, 5'd7);
    stall = 6'b000110;
    cycle(); cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    stall = 6'b000000; if_valid = 1'b1; if_pc = 32'hBFC0_0000;
    cycle();
    cycle();

    // Continuous interlock drives the preloaded counter into saturation.
    inst_rdata = mk(5'd5, 5'd6);
    set_src(0, 1'b1, 1'b1, 5'd5, 32'h77);
    stall = 6'b000110;
    repeat (24) cycle();
    clear_srcs();

    for (int n = 0; n < 400; n++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 5)       stall = 6'b000000;
      else if (r < 7)  stall = 6'b000110;
      else if (r == 7) stall = 6'b000010;
      else if (r == 8) stall = 6'b000111;
      else             stall = 6'b000100;
      rst = ($urandom_range(0, 49) == 0);
      if_valid = 1'($urandom);
      if_pc = $urandom;
      inst_rdata = {6'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
      rf_rdata1 = $urandom;
      rf_rdata2 = $urandom;
      for (int i = 0; i < NSRC; i++)
        set_src(i, 1'($urandom), 1'($urandom), 5'($urandom_range(0, 7)), $urandom);
      cycle();
    end

    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
